seg7_scroll_display: RTL

Parametrised multiplexed seven-segment driver for signed decimal values wider than the visible window. On a start pulse it captures a binary magnitude and a sign flag, then converts the magnitude to BCD with a sequential shift-add-3 (double-dabble) engine. It shows a sign slot plus a WIN-digit window that the shl/shr buttons scroll across the DIGITS-digit result. It sits between the switch/button inputs and the board's common-anode display, and supersedes the fixed 16-bit/3-digit driver.

---
 rtl/seg7_scroll_display.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scroll_display.sv
// seg7_scroll_display: signed decimal driver for a multiplexed common-anode seven-segment display.
// The binary magnitude is converted to BCD with a sequential double-dabble engine. A sign slot
// and a WIN-digit window, scrolled by shl/shr, show part of the DIGITS-digit result.
// Ports:
//   clk, rst (async, active-high)
//   start  button; a rising edge captures value/sign and starts conversion
//   sign   1 = negative, sampled with value
//   shl    button; scrolls toward less significant digits
//   shr    button; scrolls toward more significant digits
//   value  [WIDTH-1:0] unsigned magnitude
//   an     [WIN:0] active-low anodes, bit WIN = sign slot (leftmost)
//   seg    [6:0] active-low segments {a,b,c,d,e,f,g}
//   busy   high during conversion
// Optional macro SEG7_LEADING_BLANK_EN: leading zeros are stored as blank (4'hF) on load.
module seg7_scroll_display #(
   parameter int WIDTH       = 16,
   parameter int DIGITS      = 5,
   parameter int WIN         = 3,
   parameter int REFRESH_DIV = 262144
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic             shl,
   input  logic             shr,
   input  logic [WIDTH-1:0] value,
   output logic [WIN:0]     an,
   output logic [6:0]       seg,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int OW = $clog2(DIGITS + 1);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int SW = $clog2(WIN + 2);
   localparam int IW = $clog2(DIGITS + WIN + 1);
   localparam logic [OW-1:0] OMAX = OW'(DIGITS - WIN);

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
   state_t state, next;

   // bits [1:0] synchronise, bit 2 holds the previous synchronised level
   logic [2:0] s_start, s_shl, s_shr;
   logic start_p, shl_p, shr_p;

   logic [WIDTH-1:0]    sh;
   logic [4*DIGITS-1:0] bcd, bcd_adj;
   logic [CW-1:0]       cnt;
   logic [3:0]          digits [DIGITS];
   logic [3:0]          load_d [DIGITS];
   logic                sign_l;
   logic [OW-1:0]       offset;

   logic [PW-1:0] presc;
   logic [SW-1:0] slot;
   logic          refresh;
   logic [IW-1:0] idx;
   logic [3:0]    cur;
   logic [WIN:0]  an_n;
   logic [6:0]    seg_n;

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0: dec = 7'b0000001;
         4'd1: dec = 7'b1001111;
         4'd2: dec = 7'b0010010;
         4'd3: dec = 7'b0000110;
         4'd4: dec = 7'b1001100;
         4'd5: dec = 7'b0100100;
         4'd6: dec = 7'b0100000;
         4'd7: dec = 7'b0001111;
         4'd8: dec = 7'b0000000;
         4'd9: dec = 7'b0000100;
         default: dec = 7'b1111111;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s_start <= '0;
         s_shl   <= '0;
         s_shr   <= '0;
      end else begin
         s_start <= {s_start[1:0], start};
         s_shl   <= {s_shl[1:0], shl};
         s_shr   <= {s_shr[1:0], shr};
      end

   assign start_p = s_start[1] & ~s_start[2];
   assign shl_p   = s_shl[1] & ~s_shl[2];
   assign shr_p   = s_shr[1] & ~s_shr[2];

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= next;

   always_comb begin
      next = state;
      busy = state != IDLE;
      next = state == IDLE ? (start_p ? CONV : IDLE) :
             state == CONV ? (cnt == CW'(1) ? LOAD : CONV) : IDLE;
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++)
         bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
   end

   // digit[0] is the most significant digit, held in the top nibble of bcd
   always_comb begin
`ifdef SEG7_LEADING_BLANK_EN
      logic lead;
      lead = 1'b1;
`endif
      for (int i = 0; i < DIGITS; i++) begin
`ifdef SEG7_LEADING_BLANK_EN
         lead = lead && bcd[4*(DIGITS-1-i) +: 4] == 4'd0;
         load_d[i] = (lead && i != DIGITS - 1) ? 4'hF : bcd[4*(DIGITS-1-i) +: 4];
`else
         load_d[i] = bcd[4*(DIGITS-1-i) +: 4];
`endif
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sh     <= '0;
         bcd    <= '0;
         cnt    <= '0;
         sign_l <= 1'b0;
         offset <= OMAX;
         for (int i = 0; i < DIGITS; i++) digits[i] <= '0;
      end else begin
         if (state == IDLE && start_p) begin
            sh     <= value;
            sign_l <= sign;
            bcd    <= '0;
            cnt    <= CW'(WIDTH);
         end
         if (state == CONV) begin
            bcd <= {bcd_adj[4*DIGITS-2:0], sh[WIDTH-1]};
            sh  <= sh << 1;
            cnt <= cnt - 1'b1;
         end
         if (state == LOAD) begin
            digits <= load_d;
            offset <= OMAX;
         end else if (state == IDLE && shl_p && !shr_p && offset != OMAX)
            offset <= offset + 1'b1;
         else if (state == IDLE && shr_p && !shl_p && offset != '0)
            offset <= offset - 1'b1;
      end

   always_comb begin
      idx = IW'(offset) + IW'(slot) - IW'(1);
      cur = 4'hF;
      for (int i = 0; i < DIGITS; i++)
         if (idx == IW'(i)) cur = digits[i];
      an_n = '1;
      for (int k = 0; k <= WIN; k++)
         if (slot == SW'(k)) an_n[WIN-k] = 1'b0;
      seg_n = slot == '0 ? (sign_l ? 7'b1111110 : 7'b1111111) : dec(cur);
   end

   // refresh trails the slot change by one cycle so an/seg load the new slot's contents
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         presc   <= '0;
         slot    <= '0;
         refresh <= 1'b0;
         an      <= '1;
         seg     <= '1;
      end else begin
         refresh <= presc == PW'(REFRESH_DIV - 1);
         presc   <= presc == PW'(REFRESH_DIV - 1) ? '0 : presc + 1'b1;
         if (presc == PW'(REFRESH_DIV - 1)) slot <= slot == SW'(WIN) ? '0 : slot + 1'b1;
         if (refresh) begin
            an  <= an_n;
            seg <= seg_n;
         end
      end
endmodule
